// File: rtl/seq_1011_tx.sv
// Serial frame transmitter: sync word, bit-stuffed payload, one guard cycle.
// Stuffing keeps the sync pattern from reappearing inside the payload.
module seq_1011_tx #(
   parameter int                SYNC_W    = 4,
   parameter logic [SYNC_W-1:0] SYNC      = 4'b1011,
   parameter int                PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid,
   input  logic [PAYLOAD_W-1:0] data,
   output logic                 ready,
   output logic                 ser_out,
   output logic                 tx_active,
   output logic                 done
);

   localparam int TW   = SYNC_W + PAYLOAD_W;
   localparam int MAXW = (SYNC_W > PAYLOAD_W) ? SYNC_W : PAYLOAD_W;
   localparam int CW   = $clog2(MAXW) + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_DATA  = 3'd2,
      ST_STUFF = 3'd3,
      ST_GUARD = 3'd4
   } state_t;

   state_t          state, state_n;
   logic            bit_n;
   logic [2:0]      hist, hist_n;
   logic [CW-1:0]   scnt, scnt_n;
   logic [CW-1:0]   dcnt, dcnt_n;
   logic [TW-1:0]   sr, sr_n;
   logic [TW-1:0]   load;
   logic            pay;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         ser_out <= 1'b0;
         hist    <= 3'b000;
         scnt    <= '0;
         dcnt    <= '0;
      end else begin
         state   <= state_n;
         ser_out <= bit_n;
         hist    <= hist_n;
         scnt    <= scnt_n;
         dcnt    <= dcnt_n;
      end
   end

   // Shift register holds the remaining sync bits followed by the payload.
   always_ff @(posedge clk) begin
      sr <= sr_n;
   end

   always_comb begin
      state_n = state;
      bit_n   = 1'b0;
      hist_n  = hist;
      scnt_n  = scnt;
      dcnt_n  = dcnt;
      sr_n    = sr;
      pay     = 1'b0;
      load    = {SYNC, data};

      case (state)
         ST_IDLE: begin
            if (valid) begin
               state_n = ST_SYNC;
               bit_n   = load[TW-1];
               sr_n    = load << 1;
               hist_n  = {2'b00, bit_n};
               scnt_n  = CW'(1);
               dcnt_n  = '0;
            end
         end
         ST_SYNC: begin
            if (scnt != CW'(SYNC_W)) begin
               bit_n  = sr[TW-1];
               sr_n   = sr << 1;
               scnt_n = scnt + CW'(1);
               hist_n = {hist[1:0], bit_n};
            end else begin
               pay = 1'b1;
            end
         end
         ST_DATA, ST_STUFF: begin
            pay = 1'b1;
         end
         ST_GUARD: begin
            state_n = ST_IDLE;
            hist_n  = 3'b000;
            scnt_n  = '0;
            dcnt_n  = '0;
         end
         default: begin
            state_n = ST_IDLE;
            hist_n  = 3'b000;
            scnt_n  = '0;
            dcnt_n  = '0;
         end
      endcase

      // Payload step: finish, insert a stuff zero, or send the next bit.
      if (pay) begin
         if (dcnt == CW'(PAYLOAD_W)) begin
            state_n = ST_GUARD;
            bit_n   = 1'b0;
         end else if (hist == 3'b101) begin
            state_n = ST_STUFF;
            bit_n   = 1'b0;
            hist_n  = {hist[1:0], 1'b0};
         end else begin
            state_n = ST_DATA;
            bit_n   = sr[TW-1];
            sr_n    = sr << 1;
            dcnt_n  = dcnt + CW'(1);
            hist_n  = {hist[1:0], bit_n};
         end
      end
   end

   assign ready     = (state == ST_IDLE);
   assign done      = (state == ST_GUARD);
   assign tx_active = (state == ST_SYNC) ||
                      (state == ST_DATA) ||
                      (state == ST_STUFF);

endmodule

// File: tb/tb_seq_1011_tx.sv
// Bench for seq_1011_tx: directed and random frames against a bit-list model.
// Also covers back-to-back frames and asynchronous mid-frame reset.
module tb_seq_1011_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       ready, ser_out, tx_active, done;

   int n_vec = 0;
   int n_err = 0;
   bit hold_valid = 1'b0;
   bit exp_q[$];

   always #5 clk = ~clk;

   seq_1011_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (valid),
      .data      (data),
      .ready     (ready),
      .ser_out   (ser_out),
      .tx_active (tx_active),
      .done      (done)
   );

   // Expected line bits: sync, payload with a 0 inserted after any 101, guard.
   function automatic void build(input logic [7:0] d);
      int n;
      exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 7; i >= 0; i--) begin
         n = exp_q.size();
         if (exp_q[n-3] && !exp_q[n-2] && exp_q[n-1])
            exp_q.push_back(1'b0);
         exp_q.push_back(d[i]);
      end
      exp_q.push_back(1'b0);
   endfunction

   // Entered and left at a falling edge in an IDLE cycle.
   task automatic tx_frame(input logic [7:0] d, input int exp_len,
                           input string tag);
      bit act_q[$];
      int len;
      int hits;
      int want;
      bit last;
      build(d);
      n_vec++;
      if (ready !== 1'b1 || ser_out !== 1'b0 ||
          tx_active !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle: ready=%b ser_out=%b tx_active=%b done=%b, want 1 0 0 0",
                  tag, ready, ser_out, tx_active, done);
      end
      valid = 1'b1;
      data  = d;
      @(negedge clk);
      valid = hold_valid;
      data  = 8'($urandom);
      len   = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
         last = (k == exp_q.size() - 1);
         act_q.push_back(ser_out);
         if (tx_active === 1'b1) len++;
         n_vec++;
         if (ser_out !== exp_q[k] || tx_active !== !last ||
             done !== last || ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s bit %0d: ser_out=%b tx_active=%b done=%b ready=%b, want %b %b %b 0",
                     tag, k, ser_out, tx_active, done, ready,
                     exp_q[k], !last, last);
         end
         if (!last) begin
            @(negedge clk);
            data = 8'($urandom);
         end
      end
      want = (exp_len != 0) ? exp_len : exp_q.size();
      n_vec++;
      if (len + 1 != want) begin
         n_err++;
         $display("FAIL %s length: got %0d cycles, want %0d", tag, len + 1, want);
      end
      hits = 0;
      for (int k = 1; k + 3 < act_q.size(); k++)
         if (act_q[k] && !act_q[k+1] && act_q[k+2] && act_q[k+3]) hits++;
      n_vec++;
      if (hits != 0) begin
         n_err++;
         $display("FAIL %s sync_scan: got %0d inner 1011 matches, want 0", tag, hits);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #3;
      n_vec++;
      if (ser_out !== 1'b0 || tx_active !== 1'b0 ||
          done !== 1'b0 || ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset: ser_out=%b tx_active=%b done=%b ready=%b, want 0 0 0 1",
                  ser_out, tx_active, done, ready);
      end
      valid = 1'b1;
      data  = 8'hFF;
      repeat (3) @(negedge clk);
      n_vec++;
      if (ser_out !== 1'b0 || tx_active !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold: ser_out=%b tx_active=%b, want 0 0",
                  ser_out, tx_active);
      end
      valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b1 || ser_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: ready=%b ser_out=%b, want 1 0", ready, ser_out);
      end
   endtask

   task automatic test_directed();
      hold_valid = 1'b0;
      tx_frame(8'h00, 13, "d00");
      tx_frame(8'hFF, 13, "dFF");
      tx_frame(8'hA5, 14, "dA5");
      tx_frame(8'h2D, 15, "d2D");
   endtask

   task automatic test_back_to_back();
      hold_valid = 1'b1;
      tx_frame(8'hA5, 14, "b2b0");
      tx_frame(8'h2D, 15, "b2b1");
      hold_valid = 1'b0;
      tx_frame(8'h00, 13, "b2b2");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         hold_valid = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
         tx_frame(8'($urandom), 0, "rand");
         if (!hold_valid) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_frame();
      hold_valid = 1'b0;
      valid = 1'b1;
      data  = 8'hFF;
      @(negedge clk);
      valid = 1'b0;
      data  = 8'h00;
      repeat (6) @(negedge clk);
      n_vec++;
      if (ser_out !== 1'b1 || tx_active !== 1'b1) begin
         n_err++;
         $display("FAIL mid_pre: ser_out=%b tx_active=%b, want 1 1", ser_out, tx_active);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (ser_out !== 1'b0 || tx_active !== 1'b0 ||
          done !== 1'b0 || ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_reset: ser_out=%b tx_active=%b done=%b ready=%b, want 0 0 0 1",
                  ser_out, tx_active, done, ready);
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || ser_out !== 1'b0) begin
         n_err++;
         $display("FAIL mid_hold: done=%b ser_out=%b, want 0 0", done, ser_out);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      tx_frame(8'h2D, 15, "post_reset");
      tx_frame(8'($urandom), 0, "post_rand");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
